stream_deserializer: RTL and testbench

STREAM_DESERIALIZER -- requirements
Module: stream_deserializer

---
 rtl/stream_deserializer.sv | 83 ++++++++
 tb/tb_stream_deserializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_deserializer.sv
// Collects LANE_W-bit beats into a DATA_O_W word; word appears the cycle after its last beat.
// Input is stalled (data_ready_o low) only while a finished word waits for the downstream.
module stream_deserializer #(
    parameter int DATA_O_W  = 16,
    parameter int LANE_W    = 1,
    parameter bit MSB_FIRST = 1'b1,
    localparam int BEATS    = DATA_O_W / ((LANE_W < 1) ? 1 : LANE_W),
    localparam int CNT_W    = $clog2(BEATS + 1)
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic [LANE_W-1:0]   data_i,
    input  logic                data_val_i,
    input  logic                data_last_i,
    output logic                data_ready_o,
    output logic [DATA_O_W-1:0] deser_data_o,
    output logic [CNT_W-1:0]    deser_data_cnt_o,
    output logic                deser_data_val_o,
    input  logic                deser_data_ready_i
);

    generate
        if (LANE_W < 1 || (DATA_O_W % ((LANE_W < 1) ? 1 : LANE_W)) != 0) begin : g_bad_cfg
            $error("stream_deserializer: LANE_W must be >= 1 and divide DATA_O_W");
        end
    endgenerate

    logic [DATA_O_W-1:0] r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_O_W-1:0] r_dat;
    logic [CNT_W-1:0]    r_out_cnt;
    logic                r_vld;

    logic                w_accept;
    logic                w_done;
    logic [CNT_W-1:0]    w_lane;
    logic [DATA_O_W-1:0] w_acc_next;

    assign data_ready_o     = !r_vld || deser_data_ready_i;
    assign w_accept         = data_val_i && data_ready_o;
    assign w_done           = (r_cnt == CNT_W'(BEATS - 1)) || data_last_i;
    assign w_lane           = MSB_FIRST ? (CNT_W'(BEATS - 1) - r_cnt) : r_cnt;

    assign deser_data_o     = r_dat;
    assign deser_data_cnt_o = r_out_cnt;
    assign deser_data_val_o = r_vld;

    // Accumulator is zero at word start, so untouched lanes of a short word stay zero.
    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[w_lane*LANE_W +: LANE_W] = data_i;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_dat     <= '0;
            r_out_cnt <= '0;
            r_vld     <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_done) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // A word finishing on the same edge as a downstream accept keeps valid high.
            if (w_accept && w_done) begin
                r_dat     <= w_acc_next;
                r_out_cnt <= r_cnt + CNT_W'(1);
                r_vld     <= 1'b1;
            end else if (r_vld && deser_data_ready_i) begin
                r_vld     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_deserializer.sv
// Five deserializer configurations run side by side, each against a queue-based word model.
module tb_stream_deserializer;

    localparam int NCFG = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vec         = 0;
    int miscompares = 0;

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int LW    = (g == 0) ? 4 : (g == 1) ? 4 : (g == 2) ? 1 : (g == 3) ? 8 : 16;
        localparam bit MF    = (g == 1) ? 1'b0 : 1'b1;
        localparam int BEATS = 16 / LW;
        localparam int CW    = $clog2(BEATS + 1);

        logic          srst;
        logic [LW-1:0] d;
        logic          dv, dl, drdy, rdy, o_vld;
        logic [15:0]   o_dat;
        logic [CW-1:0] o_cnt;

        stream_deserializer #(
            .DATA_O_W  (16),
            .LANE_W    (LW),
            .MSB_FIRST (MF)
        ) dut (
            .clk_i              (clk),
            .srst_i             (srst),
            .data_i             (d),
            .data_val_i         (dv),
            .data_last_i        (dl),
            .data_ready_o       (rdy),
            .deser_data_o       (o_dat),
            .deser_data_cnt_o   (o_cnt),
            .deser_data_val_o   (o_vld),
            .deser_data_ready_i (drdy)
        );

        // Reference: collect accepted beats in a queue, place them by rule when the word ends.
        logic [LW-1:0] q[$];
        logic [31:0]   mlog[$];
        logic [15:0]   m_dat = '0;
        int            m_cnt = 0;
        bit            m_vld = 1'b0;
        bit            m_rdy, m_fin;
        bit            armed = 1'b0;
        bit            done  = 1'b0;
        int            ndir  = 0;
        int            vcount = 0;

        always @(posedge clk) begin
            armed = 1'b1;
            m_rdy = !m_vld || drdy;
            m_fin = 1'b0;
            if (srst) begin
                q.delete();
                m_vld = 1'b0;
                m_dat = '0;
                m_cnt = 0;
            end else begin
                if (dv && m_rdy) begin
                    q.push_back(d);
                    m_fin = (q.size() == BEATS) || dl;
                end
                if (m_fin) begin
                    m_dat = '0;
                    foreach (q[k]) m_dat[(MF ? (BEATS - 1 - k) : k)*LW +: LW] = q[k];
                    m_cnt = q.size();
                    m_vld = 1'b1;
                    mlog.push_back({16'(m_cnt), m_dat});
                    q.delete();
                end else if (m_vld && drdy) begin
                    m_vld = 1'b0;
                end
            end
        end

        always @(negedge clk) begin
            if (armed) begin
                vec++;
                if (o_vld !== m_vld || o_dat !== m_dat || o_cnt !== CW'(m_cnt) ||
                    rdy !== (!m_vld || drdy)) begin
                    miscompares++;
                    $display("FAIL cfg%0d cycle_check t=%0t got vld=%b dat=%h cnt=%0d rdy=%b want vld=%b dat=%h cnt=%0d rdy=%b",
                             g, $time, o_vld, o_dat, o_cnt, rdy, m_vld, m_dat, m_cnt, (!m_vld || drdy));
                end
            end
        end

        task automatic beat(input logic [LW-1:0] v, input bit last);
            bit ok;
            ok = 1'b0;
            d  = v;
            dv = 1'b1;
            dl = last;
            for (int t = 0; t < 100 && !ok; t++) begin
                @(negedge clk);
                ok = rdy;
                @(posedge clk);
                #1;
            end
            if (!ok) begin
                miscompares++;
                $display("FAIL cfg%0d beat_accept got not-accepted want accepted within 100 cycles", g);
            end
            dl = 1'b0;
        endtask

        task automatic idle(input int n);
            dv = 1'b0;
            dl = 1'b0;
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        initial begin
            logic [15:0] w;
            srst = 1'b1; dv = 1'b0; dl = 1'b0; d = '0; drdy = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            srst = 1'b0;
            idle(1);

            if (g == 0) begin
                beat(LW'(4'hA), 0); beat(LW'(4'h5), 1);
                beat(LW'(4'h1), 0); beat(LW'(4'h2), 0); beat(LW'(4'h3), 0); beat(LW'(4'h4), 0);
                idle(2);
                drdy = 1'b0;
                beat(LW'(4'hA), 0); beat(LW'(4'h5), 0); beat(LW'(4'hC), 0); beat(LW'(4'h3), 0);
                fork
                    beat(LW'(4'h6), 0);
                    begin
                        repeat (10) begin @(posedge clk); #1; end
                        drdy = 1'b1;
                    end
                join
                beat(LW'(4'h7), 0); beat(LW'(4'h8), 0); beat(LW'(4'h9), 0);
            end else if (g == 1) begin
                beat(LW'(4'h3), 0); beat(LW'(4'hC), 0); beat(LW'(4'h5), 0); beat(LW'(4'hA), 0);
                beat(LW'(4'h7), 0); beat(LW'(4'h8), 1);
            end else if (g == 2) begin
                w = 16'hA5C3;
                for (int i = 15; i >= 0; i--) beat(LW'(w[i]), 0);
                idle(1);
                for (int i = 0; i < 7; i++) beat(LW'(1), 0);
                srst = 1'b1;
                idle(1);
                srst = 1'b0;
                for (int i = 0; i < 16; i++) beat(LW'(1), 0);
            end else if (g == 3) begin
                for (int i = 0; i < 200; i++) begin
                    beat(LW'($urandom), 0);
                    if (o_vld) vcount++;
                end
            end else begin
                beat(LW'(16'h1234), 0); beat(LW'(16'hBEEF), 0);
            end
            idle(3);
            ndir = mlog.size();

            for (int c = 0; c < 1500; c++) begin
                srst = ($urandom_range(0, 99) == 0);
                dv   = ($urandom_range(0, 9) < 7);
                d    = LW'($urandom);
                dl   = ($urandom_range(0, 7) == 0);
                drdy = ($urandom_range(0, 9) < 7);
                @(posedge clk);
                #1;
            end
            srst = 1'b0;
            drdy = 1'b1;
            idle(4);
            done = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vec++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int c = 0; c < 20000 && !all_done; c++) begin
            @(posedge clk);
            all_done = cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done && cfg[4].done;
        end
        if (!all_done) begin
            miscompares++;
            $display("FAIL run_timeout got unfinished want all configurations done");
        end

        chk("lw4_msb_ndir",   32'(cfg[0].ndir),   32'd4);
        chk("lw4_msb_short",  cfg[0].mlog[0],     32'h0002_A500);
        chk("lw4_msb_1234",   cfg[0].mlog[1],     32'h0004_1234);
        chk("lw4_msb_a5c3",   cfg[0].mlog[2],     32'h0004_A5C3);
        chk("lw4_msb_stall",  cfg[0].mlog[3],     32'h0004_6789);
        chk("lw4_lsb_ndir",   32'(cfg[1].ndir),   32'd2);
        chk("lw4_lsb_a5c3",   cfg[1].mlog[0],     32'h0004_A5C3);
        chk("lw4_lsb_short",  cfg[1].mlog[1],     32'h0002_0087);
        chk("lw1_ndir",       32'(cfg[2].ndir),   32'd2);
        chk("lw1_a5c3",       cfg[2].mlog[0],     32'h0010_A5C3);
        chk("lw1_after_rst",  cfg[2].mlog[1],     32'h0010_FFFF);
        chk("lw8_words",      32'(cfg[3].ndir),   32'd100);
        chk("lw8_val_pulses", 32'(cfg[3].vcount), 32'd100);
        chk("lw16_ndir",      32'(cfg[4].ndir),   32'd2);
        chk("lw16_w0",        cfg[4].mlog[0],     32'h0001_1234);
        chk("lw16_w1",        cfg[4].mlog[1],     32'h0001_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
        $finish;
    end

endmodule
